// File: rtl/dmem_init_loader.sv
// Debug-side data-memory loader: packs a 32-bit word stream into pairs and
// issues each pair as one dual-word store on the data-memory port.
module dmem_init_loader #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic [31:0]       mem_wd2,
    output logic [2:0]        mem_funct3,
    output logic              mem_enable_half,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT_LO,
        COLLECT_HI,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  remaining;
    logic [31:0]       lo;
    logic              err_q;
    logic              zero_done_q;

    logic              start_aligned;
    logic              load_go;
    logic              last_word;

    assign start_aligned = start && (state == IDLE) && (base_addr[2:0] == 3'b000);
    assign load_go       = start_aligned && (num_words != '0);
    assign last_word     = (remaining == CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default first, so no path through the case
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (load_go) state_next = COLLECT_LO;
            COLLECT_LO: if (in_valid) state_next = last_word ? WRITE : COLLECT_HI;
            COLLECT_HI: if (in_valid) state_next = WRITE;
            WRITE:      state_next = (remaining == '0) ? DONE : COLLECT_LO;
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Handshake and strobes are pure state decodes: no in_valid -> in_ready path.
    assign in_ready        = (state == COLLECT_LO) || (state == COLLECT_HI);
    assign mem_write       = (state == WRITE);
    assign mem_enable_half = (state == WRITE);
    assign busy            = (state == COLLECT_LO) || (state == COLLECT_HI) || (state == WRITE);
    assign done            = (state == DONE) || zero_done_q;
    assign err             = err_q;
    assign mem_read        = 1'b0;
    assign mem_funct3      = 3'b010;

    // Store address/data are loaded on the edge that enters WRITE and then
    // hold until the next pair; mem_wd2 doubles as the hi-word register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr    <= '0;
            remaining   <= '0;
            lo          <= '0;
            mem_addr    <= '0;
            mem_wd      <= '0;
            mem_wd2     <= '0;
            err_q       <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            err_q       <= start && ((state != IDLE) || (base_addr[2:0] != 3'b000));
            zero_done_q <= start_aligned && (num_words == '0);

            case (state)
                IDLE: begin
                    if (load_go) begin
                        cur_addr  <= base_addr;
                        remaining <= num_words;
                    end
                end
                COLLECT_LO: begin
                    if (in_valid) begin
                        lo        <= in_data;
                        remaining <= remaining - CNT_W'(1);
                        if (last_word) begin
                            mem_addr <= cur_addr;
                            mem_wd   <= in_data;
                            mem_wd2  <= '0;
                        end
                    end
                end
                COLLECT_HI: begin
                    if (in_valid) begin
                        remaining <= remaining - CNT_W'(1);
                        mem_addr  <= cur_addr;
                        mem_wd    <= lo;
                        mem_wd2   <= in_data;
                    end
                end
                WRITE: begin
                    cur_addr <= cur_addr + ADDR_W'(8);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_init_loader.md
Name: dmem_init_loader

Overview:
Debug-side loader that fills data memory at high speed before program execution. It accepts a stream of 32-bit words over a valid/ready handshake and packs consecutive words into pairs. Each pair is issued as one word-store on the data-memory port: first word on the primary write-data bus, second on the secondary bus, with half-speed enable asserted. The block sits directly upstream of the data memory and is muxed onto its port only while busy.

Parameters:
ADDR_W, 9, data-memory byte-address width (matches memory address input)
CNT_W, 8, width of word-count input; max load = 2^CNT_W-1 words

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a load
base_addr  input  ADDR_W  first byte address; must be 8-byte aligned
num_words  input  CNT_W  number of 32-bit words to load
in_valid  input  1  stream word valid
in_data  input  32  stream word
in_ready  output  1  loader accepts in_data this cycle
mem_write  output  1  store strobe to data memory
mem_read  output  1  constant 0
mem_addr  output  ADDR_W  store byte address
mem_wd  output  32  primary write data (lower word of pair)
mem_wd2  output  32  secondary write data (upper word of pair)
mem_funct3  output  3  constant 3'b010 (word store)
mem_enable_half  output  1  asserted together with mem_write
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at end of load
err  output  1  one-cycle pulse on rejected start

Behaviour:
- Reset: state IDLE. in_ready, mem_write, mem_enable_half, busy, done, err = 0. mem_addr, mem_wd, mem_wd2 = 0. Internal address, remaining count, lo/hi registers = 0.
- States: IDLE, COLLECT_LO, COLLECT_HI, WRITE, DONE. All outputs are registered or decoded from state. No combinational path from in_valid to in_ready.
- IDLE:
  - start with base_addr[2:0]!=0: err pulses the next cycle; stay IDLE.
  - start with num_words==0: done pulses the next cycle; stay IDLE; no write.
  - Otherwise: latch base_addr into cur_addr and num_words into remaining; go to COLLECT_LO; busy=1.
- COLLECT_LO:
  - in_ready=1.
  - On in_valid: lo<=in_data, remaining--.
  - If remaining becomes 0: hi<=0, go to WRITE (odd tail). Else go to COLLECT_HI.
  - No in_valid: hold state, no timeout.
- COLLECT_HI:
  - in_ready=1.
  - On in_valid: hi<=in_data, remaining--, go to WRITE.
- WRITE:
  - Exactly one cycle: mem_write=1, mem_enable_half=1, mem_addr=cur_addr, mem_wd=lo, mem_wd2=hi, in_ready=0.
  - Next: cur_addr += 8, modulo 2^ADDR_W (wrap 0x1F8 -> 0x000).
  - Go to DONE if remaining==0, else COLLECT_LO.
- DONE: done=1 for one cycle, busy=0 in the same cycle; go to IDLE.
- Latency:
  - The write cycle immediately follows acceptance of the second word of a pair, or of the odd last word.
  - done occurs one cycle after the final write.
  - Minimum load time for N words with in_valid held high: 3*ceil(N/2) + 1 cycles after start.
- start while busy (any non-IDLE state): ignored; err pulses one cycle; load continues unaffected.
- mem_addr, mem_wd, mem_wd2 hold their last values when mem_write=0. The consumer qualifies them with mem_write only.
- Reset mid-load: next cycle IDLE with all outputs at reset values. No partial pair is written. No done pulse.

Test Plan:
- base=0x040, N=4, words 0x11111111, 0x22222222, 0x33333333, 0x44444444, in_valid held high -> writes (0x040, wd=0x11111111, wd2=0x22222222) and (0x048, wd=0x33333333, wd2=0x44444444); funct3=010 and enable_half=1 on both; done 1 cycle after second write; total 7 cycles.
- base=0x000, N=3, words A, B, C -> writes (0x000, A, B) and (0x008, C, 0x00000000); then done.
- base=0x1F8, N=4 -> second write at mem_addr=0x000 (wrap); busy drops with done.
- N=2 with in_valid low for 5 cycles between words -> in_ready stays high, no write until second word accepted; single write at base.
- base=0x044 start -> err pulse, no write, busy stays 0. N=0 start -> done pulse, no write. start pulsed mid-load -> err pulse, write sequence unchanged.
- N=4: assert rst in the cycle after the third word is accepted -> no further mem_write, done never pulses, in_ready=0, busy=0; new load afterwards behaves normally.
